conv3x3_stream: RTL and testbench

- Downstream of the frame BRAM controller when it runs in process mode.
- Consumes the column-strip pixel stream: 3 horizontally adjacent pixels per row, rows top to bottom, strip origin advancing one column per strip.
- Assembles 3x3 windows, applies a signed 3x3 kernel, emits one saturated 8-bit result per window in column-major order.
- Feeds the write side of the output frame buffer.

---
 rtl/conv3x3_stream.sv | 193 +++++++++++++++++++
 tb/tb_conv3x3_stream.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_stream.sv
// 3x3 signed-kernel convolver on a column-strip pixel stream, two-stage pipeline.
// Define CONV_ABS_EN to clamp the magnitude of the shifted sum instead of zeroing negatives.
module conv3x3_stream #(
   parameter int PIXEL_WIDTH  = 8,
   parameter int COEF_WIDTH   = 8,
   parameter int IMAGE_WIDTH  = 10,
   parameter int IMAGE_HEIGHT = 10,
   parameter int SHIFT        = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_valid,
   input  logic [PIXEL_WIDTH-1:0] i_pixel,
   input  logic                   i_sof,
   input  logic                   i_coef_we,
   input  logic [3:0]             i_coef_addr,
   input  logic [COEF_WIDTH-1:0]  i_coef_data,
   output logic                   o_valid,
   output logic [PIXEL_WIDTH-1:0] o_pixel,
   output logic                   o_eof
);

   localparam int PW    = PIXEL_WIDTH;
   localparam int CW    = COEF_WIDTH;
   localparam int PRODW = PW + CW + 1;
   localparam int SUMW  = PRODW + 4;
   localparam int RW    = $clog2(IMAGE_HEIGHT);
   localparam int CLW   = $clog2(IMAGE_WIDTH);

   localparam logic [RW-1:0]  ROW_LAST = RW'(IMAGE_HEIGHT - 1);
   localparam logic [CLW-1:0] COL_LAST = CLW'(IMAGE_WIDTH - 3);
   localparam logic signed [SUMW-1:0] PMAX =
      {{(SUMW-PW){1'b0}}, {PW{1'b1}}};

   typedef enum logic {FILL, RUN} state_e;

   state_e         state_q, state_d, st_eff;
   logic [1:0]     pix_q, pix_d, pix_eff;
   logic [RW-1:0]  row_q, row_d, row_eff;
   logic [CLW-1:0] col_q, col_d, col_eff;
   logic           trip_done, fire, last_win;

   logic [PW-1:0] stg_q [0:1];
   logic [PW-1:0] win_q [0:8];
   logic [PW-1:0] win_d [0:8];
   logic [CW-1:0] coef_q [0:8];

   logic signed [PRODW-1:0] prod_d [0:8];
   logic signed [PRODW-1:0] prod_q [0:8];
   logic                    v1_q, eof1_q;

   logic signed [SUMW-1:0] sum, shifted, mag;
   logic [PW-1:0]          pix_c;

   logic          o_valid_q, o_eof_q;
   logic [PW-1:0] o_pixel_q;

   // Start-of-frame overrides the current position before anything is decided.
   always_comb begin
      pix_eff   = i_sof ? 2'd0 : pix_q;
      row_eff   = i_sof ? '0 : row_q;
      col_eff   = i_sof ? '0 : col_q;
      st_eff    = i_sof ? FILL : state_q;
      trip_done = i_valid && (pix_eff == 2'd2);
      fire      = trip_done && (st_eff == RUN);
      last_win  = (row_eff == ROW_LAST) && (col_eff == COL_LAST);
   end

   always_comb begin
      state_d = state_q;
      pix_d   = pix_q;
      row_d   = row_q;
      col_d   = col_q;
      if (i_valid) begin
         state_d = st_eff;
         pix_d   = pix_eff + 2'd1;
         row_d   = row_eff;
         col_d   = col_eff;
         if (trip_done) begin
            pix_d = 2'd0;
            if (row_eff == ROW_LAST) begin
               row_d   = '0;
               state_d = FILL;
               col_d   = (col_eff == COL_LAST) ? '0 : col_eff + CLW'(1);
            end else begin
               row_d = row_eff + RW'(1);
               if (row_eff >= RW'(1)) state_d = RUN;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FILL;
         pix_q   <= '0;
         row_q   <= '0;
         col_q   <= '0;
      end else begin
         state_q <= state_d;
         pix_q   <= pix_d;
         row_q   <= row_d;
         col_q   <= col_d;
      end
   end

   always_comb begin
      for (int k = 0; k < 6; k++) win_d[k] = win_q[k+3];
      win_d[6] = stg_q[0];
      win_d[7] = stg_q[1];
      win_d[8] = i_pixel;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stg_q[0] <= '0;
         stg_q[1] <= '0;
         for (int k = 0; k < 9; k++) win_q[k] <= '0;
      end else if (i_valid) begin
         if (pix_eff == 2'd0) stg_q[0] <= i_pixel;
         if (pix_eff == 2'd1) stg_q[1] <= i_pixel;
         if (trip_done) begin
            for (int k = 0; k < 9; k++) win_q[k] <= win_d[k];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < 9; k++)
            coef_q[k] <= (k == 4) ? CW'(1) : '0;
      end else begin
         for (int k = 0; k < 9; k++)
            if (i_coef_we && (i_coef_addr == 4'(k)))
               coef_q[k] <= i_coef_data;
      end
   end

   // Products see the freshly completed window, not the registered one.
   always_comb begin
      for (int k = 0; k < 9; k++)
         prod_d[k] = PRODW'($signed({1'b0, win_d[k]}))
                   * PRODW'($signed(coef_q[k]));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v1_q   <= 1'b0;
         eof1_q <= 1'b0;
         for (int k = 0; k < 9; k++) prod_q[k] <= '0;
      end else begin
         v1_q   <= fire;
         eof1_q <= fire && last_win;
         if (fire) begin
            for (int k = 0; k < 9; k++) prod_q[k] <= prod_d[k];
         end
      end
   end

   always_comb begin
      sum = '0;
      for (int k = 0; k < 9; k++) sum = sum + SUMW'(prod_q[k]);
      shifted = sum >>> SHIFT;
`ifdef CONV_ABS_EN
      mag = (shifted < 0) ? -shifted : shifted;
`else
      mag = shifted;
`endif
      if (mag < 0)
         pix_c = '0;
      else if (mag > PMAX)
         pix_c = '1;
      else
         pix_c = mag[PW-1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_valid_q <= 1'b0;
         o_eof_q   <= 1'b0;
         o_pixel_q <= '0;
      end else begin
         o_valid_q <= v1_q;
         o_eof_q   <= eof1_q;
         if (v1_q) o_pixel_q <= pix_c;
      end
   end

   assign o_valid = o_valid_q;
   assign o_eof   = o_eof_q;
   assign o_pixel = o_pixel_q;

endmodule

// File: tb/tb_conv3x3_stream.sv
// Scoreboard bench for conv3x3_stream: two instances (SHIFT 0 and 3) share one stream.
// Expected windows come from a direct 3x3 image/kernel model.
module tb_conv3x3_stream;

   localparam int W = 5;
   localparam int H = 5;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       i_valid = 1'b0;
   logic [7:0] i_pixel = '0;
   logic       i_sof = 1'b0;
   logic       i_coef_we = 1'b0;
   logic [3:0] i_coef_addr = '0;
   logic [7:0] i_coef_data = '0;
   logic       o_valid0, o_eof0, o_valid1, o_eof1;
   logic [7:0] o_pixel0, o_pixel1;

   always #5 clk = ~clk;

   conv3x3_stream #(
      .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .SHIFT(0)
   ) u0 (
      .clk(clk), .reset(reset), .i_valid(i_valid),
      .i_pixel(i_pixel), .i_sof(i_sof),
      .i_coef_we(i_coef_we), .i_coef_addr(i_coef_addr),
      .i_coef_data(i_coef_data),
      .o_valid(o_valid0), .o_pixel(o_pixel0), .o_eof(o_eof0)
   );

   conv3x3_stream #(
      .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .SHIFT(3)
   ) u1 (
      .clk(clk), .reset(reset), .i_valid(i_valid),
      .i_pixel(i_pixel), .i_sof(i_sof),
      .i_coef_we(i_coef_we), .i_coef_addr(i_coef_addr),
      .i_coef_data(i_coef_data),
      .o_valid(o_valid1), .o_pixel(o_pixel1), .o_eof(o_eof1)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int p0;
      int p1;
      bit eof;
      int cyc;
   } exp_t;

   exp_t q[$];
   int   img [H][W];
   int   coef_m [9];
   int   n_chk = 0;
   int   n_pass = 0;

   function automatic void check(bit ok, string name, int act, int exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                    name, act, exp, cyc);
   endfunction

   function automatic int win_val(int r0, int c0, int sh);
      int s = 0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            s += img[r0+i][c0+j] * coef_m[i*3+j];
      s = s >>> sh;
`ifdef CONV_ABS_EN
      if (s < 0) s = -s;
`endif
      if (s < 0) s = 0;
      if (s > 255) s = 255;
      return s;
   endfunction

   always @(negedge clk) begin
      if (reset && o_valid0) begin
         if (q.size() == 0) begin
            check(1'b0, "spurious window", o_pixel0, -1);
         end else begin
            exp_t e;
            e = q.pop_front();
            check(o_pixel0 == 8'(e.p0), "pixel shift0", o_pixel0, e.p0);
            check(o_pixel1 == 8'(e.p1), "pixel shift3", o_pixel1, e.p1);
            check(o_eof0 == e.eof, "eof", o_eof0, e.eof);
            check(cyc == e.cyc, "latency", cyc, e.cyc);
            check(o_valid1 == 1'b1, "valid shift3", o_valid1, 1);
         end
      end else if (reset && (o_eof0 || o_valid1)) begin
         check(1'b0, "eof/valid without valid", o_eof0, 0);
      end
   end

   task automatic pix(int v, bit sof);
      @(negedge clk);
      i_valid = 1'b1;
      i_pixel = 8'(v);
      i_sof   = sof;
   endtask

   task automatic idle();
      @(negedge clk);
      i_valid = 1'b0;
      i_sof   = 1'b0;
   endtask

   task automatic send_frame(bit sof, int gap_mode, int limit);
      int n = 0;
      for (int c = 0; c <= W - 3; c++)
         for (int r = 0; r < H; r++)
            for (int k = 0; k < 3; k++) begin
               if (n < limit) begin
                  int g;
                  pix(img[r][c+k], sof && (n == 0));
                  if (k == 2 && r >= 2) begin
                     exp_t e;
                     e.p0  = win_val(r - 2, c, 0);
                     e.p1  = win_val(r - 2, c, 3);
                     e.eof = (c == W - 3) && (r == H - 1);
                     e.cyc = cyc + 2;
                     q.push_back(e);
                  end
                  n++;
                  g = (gap_mode == 1) ? 1 :
                      (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
                  for (int i = 0; i < g; i++) idle();
               end
            end
      idle();
   endtask

   task automatic wait_drain(string name);
      int t = 0;
      while (q.size() != 0 && t < 40) begin
         @(negedge clk);
         t++;
      end
      check(q.size() == 0, name, q.size(), 0);
   endtask

   task automatic write_coef(int idx, int val);
      @(negedge clk);
      i_coef_we   = 1'b1;
      i_coef_addr = 4'(idx);
      i_coef_data = 8'(val);
      if (idx < 9) coef_m[idx] = int'($signed(8'(val)));
      @(negedge clk);
      i_coef_we = 1'b0;
   endtask

   task automatic set_kernel(int centre, int other);
      for (int k = 0; k < 9; k++) write_coef(k, (k == 4) ? centre : other);
   endtask

   task automatic fill_ramp();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) img[r][c] = r * W + c;
   endtask

   task automatic fill_const(int v);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) img[r][c] = v;
   endtask

   task automatic fill_rand();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(0, 255));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < 9; k++) coef_m[k] = (k == 4) ? 1 : 0;
      repeat (3) @(negedge clk);
      check(o_valid0 == 1'b0, "reset valid", o_valid0, 0);
      check(o_pixel0 == 8'd0, "reset pixel", o_pixel0, 0);
      check(o_eof0 == 1'b0, "reset eof", o_eof0, 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      fill_ramp();
      send_frame(1'b1, 0, W * H * 3);
      wait_drain("drain identity");

      send_frame(1'b1, 1, W * H * 3);
      wait_drain("drain identity gapped");

      set_kernel(1, 1);
      fill_const(200);
      send_frame(1'b1, 0, W * H * 3);
      wait_drain("drain sat");
      fill_const(16);
      send_frame(1'b0, 0, W * H * 3);
      wait_drain("drain const16");

      set_kernel(0, -1);
      fill_const(10);
      send_frame(1'b1, 0, W * H * 3);
      wait_drain("drain negative");

      set_kernel(1, 0);
      write_coef(12, 8'h55);
      for (int n = 0; n < 7; n++) pix(int'($urandom_range(0, 255)), 1'b0);
      fill_ramp();
      send_frame(1'b1, 0, W * H * 3);
      wait_drain("drain abort");

      for (int f = 0; f < 4; f++) begin
         for (int k = 0; k < 9; k++)
            write_coef(k, int'($urandom_range(0, 255)));
         fill_rand();
         send_frame(f[0], 2, W * H * 3);
         wait_drain("drain random");
      end

      begin
         int t = 0;
         set_kernel(2, -1);
         fill_ramp();
         send_frame(1'b1, 0, 13);
         while (!o_valid0 && t < 10) begin
            @(negedge clk);
            t++;
         end
         check(o_valid0 == 1'b1, "valid before reset", o_valid0, 1);
         #2 reset = 1'b0;
         #1;
         check(o_valid0 == 1'b0, "async valid drop", o_valid0, 0);
         check(o_eof0 == 1'b0, "async eof drop", o_eof0, 0);
         check(o_valid1 == 1'b0, "async valid drop 3", o_valid1, 0);
         q.delete();
         for (int k = 0; k < 9; k++) coef_m[k] = (k == 4) ? 1 : 0;
         repeat (2) @(negedge clk);
         reset = 1'b1;
         @(negedge clk);
         send_frame(1'b0, 0, W * H * 3);
         wait_drain("drain after reset");
      end

      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
